// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: START/BIN request side and BUSY/DONE/BCD/OVF result side of the converter.
// BIN2BCD_SEG_EN adds the registered 7-segment field SEG.
interface bin2bcd_seq_if #(
  parameter int BIN_W = 8,
  parameter int DIG   = 3
);
  logic             START;
  logic [BIN_W-1:0] BIN;
  logic             BUSY;
  logic             DONE;
  logic [4*DIG-1:0] BCD;
  logic             OVF;
`ifdef BIN2BCD_SEG_EN
  logic [7*DIG-1:0] SEG;

  modport master (output START, BIN, input BUSY, DONE, BCD, OVF, SEG);
  modport slave  (input START, BIN, output BUSY, DONE, BCD, OVF, SEG);
`else
  modport master (output START, BIN, input BUSY, DONE, BCD, OVF);
  modport slave  (input START, BIN, output BUSY, DONE, BCD, OVF);
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: double-dabble binary->BCD, one shift per clock, DONE BIN_W clocks after the accepting edge.
// START is ignored (not queued) while busy or in DONE; BIN2BCD_SEG_EN adds the SEG display output.
module bin2bcd_seq #(
  parameter int BIN_W = 8,
  parameter int DIG   = 3
) (
  input  logic          CLOCK_50,
  input  logic          RST_N,
  bin2bcd_seq_if.slave  bus
);

  localparam int CW = $clog2(BIN_W + 1);
  localparam int BW = 4 * DIG;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  logic [BIN_W-1:0] shreg;
  logic [BW-1:0]    work;
  logic             ovf_acc;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic [BW-1:0]    bcd_q;
  logic             ovf_q;

  logic [BW-1:0]    adj;
  logic [BW-1:0]    work_nxt;
  logic             bit_out;
  logic             ovf_fin;

  // Add-3 on every digit >= 5 so the following doubling carries correctly into the next digit.
  always_comb begin
    adj = work;
    for (int i = 0; i < DIG; i++) begin
      if (work[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
      end
    end
  end

  assign work_nxt = {adj[BW-2:0], shreg[BIN_W-1]};
  assign bit_out  = adj[BW-1];
  assign ovf_fin  = ovf_acc | bit_out;

`ifdef BIN2BCD_SEG_EN
  logic [7*DIG-1:0] seg_q;
  logic [7*DIG-1:0] seg_nxt;
  logic             lead_blank;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b000_0001;
      4'd1:    seg_code = 7'b100_1111;
      4'd2:    seg_code = 7'b001_0010;
      4'd3:    seg_code = 7'b000_0110;
      4'd4:    seg_code = 7'b100_1100;
      4'd5:    seg_code = 7'b010_0100;
      4'd6:    seg_code = 7'b010_0000;
      4'd7:    seg_code = 7'b000_1111;
      4'd8:    seg_code = 7'b000_0000;
      4'd9:    seg_code = 7'b000_1100;
      default: seg_code = 7'b111_1111;
    endcase
  endfunction

  // Walk from the top digit down; blanking stops at the first nonzero digit, and the ones digit always shows.
  always_comb begin
    seg_nxt    = '1;
    lead_blank = 1'b1;
    if (!ovf_fin) begin
      for (int i = DIG - 1; i >= 0; i--) begin
        if ((work_nxt[4*i +: 4] != 4'd0) || (i == 0)) begin
          lead_blank = 1'b0;
        end
        seg_nxt[7*i +: 7] = lead_blank ? 7'b111_1111 : seg_code(work_nxt[4*i +: 4]);
      end
    end
  end

  assign bus.SEG = seg_q;
`endif

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      shreg   <= '0;
      work    <= '0;
      ovf_acc <= 1'b0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef BIN2BCD_SEG_EN
      seg_q   <= '1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.START) begin
            shreg   <= bus.BIN;
            work    <= '0;
            ovf_acc <= 1'b0;
            cnt     <= CW'(BIN_W);
            busy_q  <= 1'b1;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          work    <= work_nxt;
          shreg   <= {shreg[BIN_W-2:0], 1'b0};
          ovf_acc <= ovf_fin;
          cnt     <= cnt - 1'b1;
          // Final shift: publish the post-step digits directly so the result lands on this edge.
          if (cnt == CW'(1)) begin
            bcd_q  <= work_nxt;
            ovf_q  <= ovf_fin;
`ifdef BIN2BCD_SEG_EN
            seg_q  <= seg_nxt;
`endif
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.BCD  = bcd_q;
  assign bus.OVF  = ovf_q;

  // Every working digit must remain a legal decimal digit after each step.
  for (genvar g = 0; g < DIG; g++) begin : g_digit_chk
    digit_ok: assert property (@(posedge CLOCK_50) disable iff (!RST_N) work[4*g +: 4] <= 4'd9);
  end

endmodule
